// File: rtl/reg_bank.sv
// 32 x 32-bit MIPS general-purpose register file with two combinational read ports.
// Writes and the synchronous reset take effect on the rising edge; reads are zero-cycle.
module reg_bank #(
  parameter logic [31:0] SP_RESET = 32'd227,
  parameter bit          BYPASS   = 1'b0,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWrite,
  input  logic [4:0]  ReadReg1,
  input  logic [4:0]  ReadReg2,
  input  logic [4:0]  WriteReg,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData1,
  output logic [31:0] ReadData2
);

  localparam int NREG   = 32;
  localparam int SP_IDX = 29;

  logic [31:0]     regs_q [NREG];
  logic [31:0]     regs_d [NREG];
  logic [NREG-1:0] wr_en;
  logic            byp_hit1;
  logic            byp_hit2;

  // Decode is qualified by RegWrite so an unknown WriteReg cannot touch storage when idle.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      wr_en[i]  = RegWrite && (WriteReg == 5'(i)) && !(ZERO_REG && (i == 0));
      regs_d[i] = wr_en[i] ? WriteData : regs_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= (i == SP_IDX) ? SP_RESET : 32'd0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  always_comb begin
    byp_hit1 = BYPASS && RegWrite && reset && (WriteReg == ReadReg1);
    byp_hit2 = BYPASS && RegWrite && reset && (WriteReg == ReadReg2);
  end

  // The hardwired-zero check wins over write-through.
  always_comb begin
    if (ZERO_REG && (ReadReg1 == 5'd0)) begin
      ReadData1 = 32'd0;
    end else if (byp_hit1) begin
      ReadData1 = WriteData;
    end else begin
      ReadData1 = regs_q[ReadReg1];
    end
  end

  always_comb begin
    if (ZERO_REG && (ReadReg2 == 5'd0)) begin
      ReadData2 = 32'd0;
    end else if (byp_hit2) begin
      ReadData2 = WriteData;
    end else begin
      ReadData2 = regs_q[ReadReg2];
    end
  end

endmodule

// File: tb/tb_reg_bank.sv
// Scoreboard bench for reg_bank: one write-through and one non-bypass instance share stimulus.
module tb_reg_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic [31:0] rd1_nb, rd2_nb, rd1_by, rd2_by;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [31:0] e1n, e2n, e1b, e2b;
  } exp_t;

  exp_t        sb_q [$];
  logic [31:0] model [32];
  bit          written [32];

  always #5 clk = ~clk;

  reg_bank #(.SP_RESET(32'd227), .BYPASS(1'b0), .ZERO_REG(1'b1)) u_nb (
    .clk(clk), .reset(reset), .RegWrite(RegWrite),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .WriteReg(WriteReg), .WriteData(WriteData),
    .ReadData1(rd1_nb), .ReadData2(rd2_nb)
  );

  reg_bank #(.SP_RESET(32'd227), .BYPASS(1'b1), .ZERO_REG(1'b1)) u_by (
    .clk(clk), .reset(reset), .RegWrite(RegWrite),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .WriteReg(WriteReg), .WriteData(WriteData),
    .ReadData1(rd1_by), .ReadData2(rd2_by)
  );

  // Value a read port should show before the coming edge.
  function automatic logic [31:0] expect_rd(input logic [4:0] idx, input bit byp);
    if (idx == 5'd0) return 32'd0;
    if (byp && reset && RegWrite && (WriteReg == idx)) return WriteData;
    return model[idx];
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_assert++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Monitor: compares one scoreboard entry per cycle against the settled outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check({e.tag, " nb.rd1"}, rd1_nb, e.e1n);
        check({e.tag, " nb.rd2"}, rd2_nb, e.e2n);
        check({e.tag, " by.rd1"}, rd1_by, e.e1b);
        check({e.tag, " by.rd2"}, rd2_by, e.e2b);
      end
    end
  end

  // Drives one cycle of inputs (called at posedge+1), queues expectations, then advances the model.
  task automatic cyc(input bit rst_n, input bit we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic [4:0] r1, input logic [4:0] r2, input bit chk, input string tag);
    exp_t e;
    reset = rst_n; RegWrite = we; WriteReg = wa; WriteData = wd;
    ReadReg1 = r1; ReadReg2 = r2;
    if (chk) begin
      e.tag = tag;
      e.e1n = expect_rd(r1, 1'b0);
      e.e2n = expect_rd(r2, 1'b0);
      e.e1b = expect_rd(r1, 1'b1);
      e.e2b = expect_rd(r2, 1'b1);
      sb_q.push_back(e);
    end
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
      model[29] = 32'h0000_00E3;
    end else if (we && (wa != 5'd0)) begin
      model[wa] = wd;
      written[wa] = 1'b1;
    end
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  xa;
    logic [4:0]  wa;
    int          miss;
    xa = 5'bxxxxx;
    reset = 1'b0; RegWrite = 1'b0; WriteReg = '0; WriteData = '0;
    ReadReg1 = '0; ReadReg2 = '0;
    for (int i = 0; i < 32; i++) begin model[i] = 32'd0; written[i] = 1'b0; end
    @(posedge clk); #1;

    // Reset, then sweep every index on both ports.
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, "rst");
    for (int i = 0; i < 32; i++)
      cyc(1'b1, 1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i), 1'b1, "reset_state");

    // Write/read r8 and r31.
    cyc(1'b1, 1'b1, 5'd8,  32'hDEADBEEF, 5'd8, 5'd31, 1'b1, "wr_r8");
    cyc(1'b1, 1'b1, 5'd31, 32'h12345678, 5'd8, 5'd31, 1'b1, "wr_r31");
    cyc(1'b1, 1'b0, 5'd0,  32'd0,        5'd8, 5'd31, 1'b1, "rd_r8_r31");
    cyc(1'b1, 1'b0, 5'd0,  32'd0,        5'd7, 5'd29, 1'b1, "others_kept");

    // Hardwired zero register.
    cyc(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b1, "zero_wr");
    cyc(1'b1, 1'b0, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b1, "zero_after");

    // Read-during-write on r5.
    cyc(1'b1, 1'b1, 5'd5, 32'h11111111, 5'd1, 5'd2, 1'b1, "r5_setup");
    cyc(1'b1, 1'b1, 5'd5, 32'h22222222, 5'd5, 5'd5, 1'b1, "r5_rdw");
    cyc(1'b1, 1'b0, 5'd5, 32'h33333333, 5'd5, 5'd5, 1'b1, "r5_after");

    // Reset beats a same-edge write; an idle unknown write index leaves storage alone.
    cyc(1'b1, 1'b1, 5'd29, 32'h00000100, 5'd29, 5'd8, 1'b1, "sp_setup");
    cyc(1'b0, 1'b1, 5'd29, 32'hAAAAAAAA, 5'd29, 5'd8, 1'b1, "rst_vs_wr");
    cyc(1'b1, 1'b0, xa,    32'h55555555, 5'd29, 5'd8, 1'b1, "rst_after");
    cyc(1'b1, 1'b0, xa,    32'h66666666, 5'd29, 5'd31, 1'b1, "x_idle");

    // Random sweep; first 31 writes cover indices 1..31.
    for (int n = 0; n < 1000; n++) begin
      wa = (n < 31) ? 5'(n + 1) : 5'($urandom_range(0, 31));
      cyc(1'b1, (n < 31) ? 1'b1 : 1'($urandom), wa, $urandom,
          5'($urandom_range(0, 31)), (n % 7 == 0) ? wa : 5'($urandom_range(0, 31)),
          1'b1, "rand");
    end

    miss = 0;
    for (int i = 1; i < 32; i++) if (!written[i]) miss++;
    check("write_coverage_missing", 32'(miss), 32'd0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_bank.md
Name: reg_bank

Overview:
- 32 x 32-bit general-purpose register file of the multicycle MIPS datapath.
- Sits directly downstream of the RegDst write-register selector. It consumes bits [4:0] of that selector's 32-bit output as the write index.
- WriteData comes from the MemtoReg selector.
- Provides two combinational read ports that feed the A/B operand registers.

Parameters:
- SP_RESET, 32'd227, value loaded into register 29 ($sp) on reset
- BYPASS, 0, 1 = a read of the register being written in the same cycle returns WriteData (write-through); 0 = returns the stored value
- ZERO_REG, 1, 1 = register 0 is hardwired to zero; 0 = register 0 is ordinary storage

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-low reset
- RegWrite  input  1  write enable, sampled on rising edge
- ReadReg1  input  5  read index, port 1 (rs)
- ReadReg2  input  5  read index, port 2 (rt)
- WriteReg  input  5  write index (selector output [4:0]; upper bits are dropped at the instantiation)
- WriteData  input  32  write data
- ReadData1  output  32  contents of ReadReg1
- ReadData2  output  32  contents of ReadReg2

Behaviour:
- Storage: 32 registers of 32 bits. No other state.
- Reset: on a rising edge with reset == 0, every register is cleared to 0, except register 29, which loads SP_RESET.
  - Reset has priority over RegWrite in the same cycle; the write is discarded.
  - Reset is synchronous. Asserting it between edges changes nothing until the next rising edge.
  - Reads stay combinational during reset and reflect the pre-reset contents until that edge.
- Write: on a rising edge with reset == 1 and RegWrite == 1, register[WriteReg] <= WriteData.
  - Write latency is one edge: the new value is visible on the read ports immediately after that edge.
- Register 0 with ZERO_REG == 1:
  - Writes to index 0 are ignored; storage stays 0.
  - Reads of index 0 always return 0, including under BYPASS.
- Read:
  - ReadDataN = register[ReadRegN], purely combinational, zero cycles.
  - Both ports may address the same register, and each returns the same value.
- Bypass, BYPASS == 1: when RegWrite == 1, reset == 1, WriteReg == ReadRegN and the index is not a hardwired zero, ReadDataN = WriteData in the same cycle.
  - This applies to each port independently.
- No bypass, BYPASS == 0: the same-cycle read returns the old value; the new value appears after the edge.
- RegWrite == 0: storage is unchanged regardless of WriteReg and WriteData.
- Unknown values: X on WriteReg while RegWrite == 0 must not corrupt storage. An implementation that gates the address decode with RegWrite is required.
- No combinational path from clk to the outputs. The only combinational paths are from the read indices, and from WriteData/WriteReg/RegWrite when BYPASS == 1.

Test Plan:
1. Reset:
   - Stimulus: hold reset = 0 for one edge, release, then read all 32 indices over both ports.
   - Required: r29 = 0x000000E3; all other registers = 0.
2. Write/read:
   - Stimulus: write 0xDEADBEEF to r8, then 0x12345678 to r31 (the jal target index). Read r8 on port 1 and r31 on port 2.
   - Required: 0xDEADBEEF and 0x12345678 one edge after each write. Other registers are unchanged.
3. Zero register:
   - Stimulus: RegWrite = 1, WriteReg = 0, WriteData = 0xFFFFFFFF; read index 0 on both ports, before and after the edge.
   - Required: always 0, under both BYPASS = 0 and BYPASS = 1.
4. Same-cycle read-during-write:
   - Setup: r5 = 0x11111111. Stimulus: write 0x22222222 to r5 while ReadReg1 = ReadReg2 = 5.
   - Required before the edge: 0x11111111 with BYPASS = 0, 0x22222222 with BYPASS = 1.
   - Required after the edge: 0x22222222 in both builds.
5. Reset versus write:
   - Setup: r29 = 0x00000100. Stimulus: reset = 0 and RegWrite = 1, WriteReg = 29, WriteData = 0xAAAAAAAA on the same edge.
   - Required: r29 = 0x000000E3 afterwards.
   - Follow-on: with RegWrite = 0 and WriteReg = X, storage is unchanged.
6. Random sweep:
   - Stimulus: 1000 random writes and reads against a reference-model array with BYPASS = 0.
   - Required: zero mismatches. Every index 1–31 is written at least once.
